// File: rtl/f1_sweep_ctrl.sv
// Sweep sequencer for a 4-input function unit: walks all 16 {a,b,c,d} vectors,
// captures the unit output per vector and grades the table against a golden mask.
module f1_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [15:0] mismatch_mask,
  output logic        fail_valid,
  output logic [3:0]  first_fail
);

  localparam int unsigned VW = 4;
  localparam int unsigned TW = 16;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [VW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] abcd_q, abcd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [TW-1:0] tt_q, tt_d;
  logic [TW-1:0] mm_q, mm_d;
  logic          fv_q, fv_d;
  logic [VW-1:0] ff_q, ff_d;
  logic          miss;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= '0;
      mm_q    <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    miss    = f_in ^ EXPECTED[vec_q];

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          vec_d   = '0;
          cnt_d   = VW'(SETTLE);
          abcd_d  = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          tt_d    = '0;
          mm_d    = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end
      RUN: begin
        if (abort) begin
          // Partial capture results are left visible for debug
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          abcd_d  = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - VW'(1);
        end else begin
          tt_d[vec_q] = f_in;
          mm_d[vec_q] = miss;
          if (miss && !fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
          if (vec_q != VW'(15)) begin
            vec_d  = vec_q + VW'(1);
            cnt_d  = VW'(SETTLE);
            abcd_d = vec_q + VW'(1);
          end else begin
            state_d = IDLE;
            vec_d   = '0;
            cnt_d   = '0;
            abcd_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a             = abcd_q[3];
  assign b             = abcd_q[2];
  assign c             = abcd_q[1];
  assign d             = abcd_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign truth_table   = tt_q;
  assign mismatch_mask = mm_q;
  assign fail_valid    = fv_q;
  assign first_fail    = ff_q;

endmodule

// File: tb/tb_f1_sweep_ctrl.sv
// Scoreboard bench for f1_sweep_ctrl: three instances (settle 2 clean, settle 2
// single-mismatch, settle 0) each driving f_in from its own a output.
module tb_f1_sweep_ctrl;

  typedef struct {
    int          inst;
    logic [15:0] tt;
    logic [15:0] mm;
    logic        pass;
    logic        fv;
    logic [3:0]  ff;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  start_r = '0;
  logic [2:0]  abort_r = '0;
  logic        flip0 = 1'b0;
  logic [2:0]  a_w, b_w, c_w, d_w, busy_w, done_w, pass_w, fv_w;
  logic [15:0] tt_w [3];
  logic [15:0] mm_w [3];
  logic [3:0]  ff_w [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   acc;
  exp_t sb[$];
  exp_t dump;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  f1_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'hFF00)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]), .f_in(a_w[0] ^ flip0),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .truth_table(tt_w[0]), .mismatch_mask(mm_w[0]),
    .fail_valid(fv_w[0]), .first_fail(ff_w[0]));

  f1_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'hFF01)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]), .f_in(a_w[1]),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .truth_table(tt_w[1]), .mismatch_mask(mm_w[1]),
    .fail_valid(fv_w[1]), .first_fail(ff_w[1]));

  f1_sweep_ctrl #(.SETTLE(0), .EXPECTED(16'hFF00)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .abort(abort_r[2]), .f_in(a_w[2]),
    .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .d(d_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .truth_table(tt_w[2]), .mismatch_mask(mm_w[2]),
    .fail_valid(fv_w[2]), .first_fail(ff_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int settle_of(input int k);
    return (k == 2) ? 0 : 2;
  endfunction

  function automatic logic [15:0] golden_of(input int k);
    return (k == 1) ? 16'hFF01 : 16'hFF00;
  endfunction

  // Reference result of a full sweep with f_in = a ^ fl
  function automatic exp_t model(input int k, input logic fl, input int dcyc);
    exp_t        e;
    logic [15:0] g;
    logic        bit_v;
    g      = golden_of(k);
    e.inst = k;
    e.tt   = '0;
    e.mm   = '0;
    e.fv   = 1'b0;
    e.ff   = '0;
    e.cyc  = dcyc;
    for (int i = 0; i < 16; i++) begin
      bit_v   = (i >= 8) ^ fl;
      e.tt[i] = bit_v;
      e.mm[i] = bit_v ^ g[i];
      if (e.mm[i] && !e.fv) begin
        e.fv = 1'b1;
        e.ff = 4'(i);
      end
    end
    e.pass = (e.mm == '0);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start for one cycle; returns the cycle number of the accept edge
  task automatic go(input int k, input logic fl, output int acc_o);
    sb.push_back(model(k, fl, cyc + 1 + 16 * (settle_of(k) + 1)));
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    acc_o = cyc;
  endtask

  function automatic logic [3:0] vec_of(input int k);
    return {a_w[k], b_w[k], c_w[k], d_w[k]};
  endfunction

  // Completion monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'(done_w[k]), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_inst", 32'(k), 32'(e.inst));
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("truth_table", 32'(tt_w[k]), 32'(e.tt));
            check("mismatch_mask", 32'(mm_w[k]), 32'(e.mm));
            check("pass", 32'(pass_w[k]), 32'(e.pass));
            check("fail_valid", 32'(fv_w[k]), 32'(e.fv));
            if (e.fv) check("first_fail", 32'(ff_w[k]), 32'(e.ff));
            check("busy_at_done", 32'(busy_w[k]), 32'd0);
            check("vec_at_done", 32'(vec_of(k)), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy_w), 32'd0);
    check("rst_done", 32'(done_w), 32'd0);
    check("rst_tt", 32'(tt_w[0]), 32'd0);
    check("rst_vec", 32'(vec_of(0)), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Clean pass on u0
    go(0, 1'b0, acc);
    check("accept_busy", 32'(busy_w[0]), 32'd1);
    tick(3);
    check("vec1_applied", 32'(vec_of(0)), 32'd1);
    tick(55);

    // Single mismatch on u1: first_fail appears at the first capture edge
    go(1, 1'b0, acc);
    tick(2);
    check("fv_before_capture", 32'(fv_w[1]), 32'd0);
    tick(1);
    check("fv_first_capture", 32'(fv_w[1]), 32'd1);
    check("ff_first_capture", 32'(ff_w[1]), 32'd0);
    tick(50);

    // Abort at vec 7 with inverted f_in so the partial table is non-zero
    flip0 = 1'b1;
    go(0, 1'b1, acc);
    tick(21);
    check("abort_vec7", 32'(vec_of(0)), 32'd7);
    abort_r[0] = 1'b1;
    tick(1);
    abort_r[0] = 1'b0;
    dump = sb.pop_back();
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_vec", 32'(vec_of(0)), 32'd0);
    check("abort_tt", 32'(tt_w[0]), 32'h007F);
    check("abort_mm", 32'(mm_w[0]), 32'h007F);
    check("abort_fv", 32'(fv_w[0]), 32'd1);
    check("abort_pass", 32'(pass_w[0]), 32'd0);
    tick(60);
    check("abort_hold_tt", 32'(tt_w[0]), 32'h007F);
    flip0 = 1'b0;
    go(0, 1'b0, acc);
    check("restart_clear_tt", 32'(tt_w[0]), 32'd0);
    check("restart_clear_fv", 32'(fv_w[0]), 32'd0);
    tick(55);

    // start and abort together in IDLE: no accept
    start_r[0] = 1'b1;
    abort_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    abort_r[0] = 1'b0;
    check("start_abort_idle", 32'(busy_w[0]), 32'd0);
    tick(2);

    // start pulse during RUN at vec 5 must not restart
    go(0, 1'b0, acc);
    tick(15);
    check("run_vec5", 32'(vec_of(0)), 32'd5);
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    tick(45);

    // Async reset mid-sweep at vec 10
    go(0, 1'b0, acc);
    tick(31);
    check("pre_reset_vec10", 32'(vec_of(0)), 32'd10);
    check("pre_reset_tt", 32'(tt_w[0]), 32'h0300);
    #2 rst_n = 1'b0;
    #1;
    dump = sb.pop_back();
    check("areset_busy", 32'(busy_w[0]), 32'd0);
    check("areset_vec", 32'(vec_of(0)), 32'd0);
    check("areset_tt", 32'(tt_w[0]), 32'd0);
    check("areset_mm", 32'(mm_w[0]), 32'd0);
    check("areset_fv", 32'(fv_w[0]), 32'd0);
    check("areset_ff", 32'(ff_w[0]), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post_reset_idle", 32'(busy_w[0]), 32'd0);

    // Back-to-back sweeps at zero settle with start held high
    for (int j = 0; j < 3; j++) sb.push_back(model(2, 1'b0, cyc + 1 + 16 + 17 * j));
    start_r[2] = 1'b1;
    tick(1);
    tick(5);
    check("b2b_vec5", 32'(vec_of(2)), 32'd5);
    tick(12);
    check("b2b_clear_tt", 32'(tt_w[2]), 32'd0);
    check("b2b_busy", 32'(busy_w[2]), 32'd1);
    tick(33);
    start_r[2] = 1'b0;
    tick(10);
    check("pending_done", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
